piece_mover: RTL

- Parametrised falling-piece controller for the Tetris playfield.
- Holds the active piece's grid column, row, rotation and shape.
- Decodes PS/2 scancodes into left/right/soft-drop/rotate/hard-drop moves, and applies gravity from an internal divider.
- Runs a spawn/fall/lock handshake with the board store, and emits pixel coordinates for the VGA renderer.

---
 rtl/tetris_pkg.sv | 25 ++
 rtl/piece_mover_key_decoder.sv | 39 +++
 rtl/piece_mover.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared types and constants for the falling-piece controller:
// scancodes, mover states, move strobes and the LFSR feedback taps.
package tetris_pkg;

    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_ROT   = 8'h75;
    localparam logic [7:0] KEY_DROP  = 8'h29;
    localparam logic [7:0] KEY_BREAK = 8'hF0;

    // x^8+x^6+x^5+x^4+1 as a shift-left Fibonacci LFSR: feedback from bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [2:0] {SPAWN, FALL, DROP, LOCK, OVER} mv_state_t;

    typedef struct packed {
        logic left;
        logic right;
        logic down;
        logic rot;
        logic drop;
    } move_t;

endpackage

// File: rtl/piece_mover_key_decoder.sv
// Turns PS/2 make codes into one-hot move strobes, swallowing the byte
// that follows each break prefix so key releases never trigger a move.
module key_decoder
    import tetris_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    output move_t      move
);

    logic break_flag;
    logic live;

    always_ff @(posedge clock) begin
        if (reset)
            break_flag <= 1'b0;
        else if (key_valid)
            break_flag <= !break_flag && (key_code == KEY_BREAK);
    end

    assign live = key_valid && !break_flag;

    always_comb begin
        move = '0;
        if (live) begin
            case (key_code)
                KEY_LEFT:  move.left  = 1'b1;
                KEY_RIGHT: move.right = 1'b1;
                KEY_DOWN:  move.down  = 1'b1;
                KEY_ROT:   move.rot   = 1'b1;
                KEY_DROP:  move.drop  = 1'b1;
                default:   move       = '0;
            endcase
        end
    end

endmodule

// File: rtl/piece_mover.sv
// Active-piece controller: spawn/fall/drop/lock FSM with gravity divider,
// keyboard moves, LFSR shape choice and pixel coordinates for the renderer.
module piece_mover
    import tetris_pkg::*;
#(
    parameter int COLS       = 15,
    parameter int ROWS       = 12,
    parameter int CELL       = 40,
    parameter int PIX_W      = 10,
    parameter int SPAWN_COL  = 5,
    parameter int GRAV_DIV   = 25_000_000,
    parameter int NUM_SHAPES = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     key_valid,
    input  logic [7:0]               key_code,
    input  logic                     blocked_l,
    input  logic                     blocked_r,
    input  logic                     blocked_d,
    input  logic                     blocked_rot,
    input  logic                     lock_ack,
    output logic [$clog2(COLS)-1:0]  col,
    output logic [$clog2(ROWS)-1:0]  row,
    output logic [1:0]               rot,
    output logic [2:0]               shape,
    output logic [PIX_W-1:0]         out_x,
    output logic [PIX_W-1:0]         out_y,
    output logic                     lock_req,
    output logic                     spawn,
    output logic                     game_over
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int GW = $clog2(GRAV_DIV + 1);
    localparam logic [CW-1:0] COL_MAX   = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_MAX   = RW'(ROWS - 1);
    localparam logic [GW-1:0] GRAV_LAST = GW'(GRAV_DIV - 1);

    generate
        if (COLS * CELL > (1 << PIX_W)) begin : g_bad_pix_w
            $error("piece_mover: COLS*CELL does not fit in PIX_W bits");
        end
    endgenerate

    mv_state_t       state;
    move_t           move;
    logic [7:0]      lfsr;
    logic [GW-1:0]   cnt;
    logic            tick_pend;
    logic            grav_tick;
    logic            any_move;
    logic            can_fall;

    key_decoder u_key_decoder (
        .clock     (clock),
        .reset     (reset),
        .key_valid (key_valid),
        .key_code  (key_code),
        .move      (move)
    );

    assign grav_tick = (state == FALL) && (cnt == GRAV_LAST);
    assign any_move  = |move;
    assign can_fall  = (row < ROW_MAX) && !blocked_d;

    assign out_x = PIX_W'(32'(col) * 32'(CELL));
    assign out_y = PIX_W'(32'(row) * 32'(CELL));

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= SPAWN;
            col       <= CW'(SPAWN_COL);
            row       <= '0;
            rot       <= '0;
            shape     <= '0;
            lock_req  <= 1'b0;
            spawn     <= 1'b0;
            game_over <= 1'b0;
            cnt       <= '0;
            tick_pend <= 1'b0;
            lfsr      <= 8'h01;
        end else begin
            lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
            case (state)
                // first cycle loads the piece, second checks the spawn cell
                SPAWN: begin
                    if (!spawn) begin
                        col       <= CW'(SPAWN_COL);
                        row       <= '0;
                        rot       <= '0;
                        shape     <= 3'(lfsr % 8'(NUM_SHAPES));
                        spawn     <= 1'b1;
                        cnt       <= '0;
                        tick_pend <= 1'b0;
                    end else begin
                        spawn <= 1'b0;
                        if (blocked_d) begin
                            state     <= OVER;
                            game_over <= 1'b1;
                        end else begin
                            state <= FALL;
                        end
                    end
                end
                FALL: begin
                    cnt <= grav_tick ? '0 : cnt + GW'(1);
                    if (move.drop) begin
                        state     <= DROP;
                        tick_pend <= 1'b0;
                    end else if (any_move) begin
                        // a tick colliding with a key waits for the new blocked_* view
                        tick_pend <= tick_pend | grav_tick;
                        if (move.left && col != '0 && !blocked_l)
                            col <= col - CW'(1);
                        if (move.right && col < COL_MAX && !blocked_r)
                            col <= col + CW'(1);
                        if (move.down && can_fall) begin
                            row <= row + RW'(1);
                            cnt <= '0;
                        end
                        if (move.rot && !blocked_rot)
                            rot <= rot + 2'd1;
                    end else if (tick_pend || grav_tick) begin
                        tick_pend <= 1'b0;
                        if (can_fall) begin
                            row <= row + RW'(1);
                        end else begin
                            state    <= LOCK;
                            lock_req <= 1'b1;
                        end
                    end
                end
                DROP: begin
                    if (can_fall) begin
                        row <= row + RW'(1);
                    end else begin
                        state    <= LOCK;
                        lock_req <= 1'b1;
                    end
                end
                LOCK: begin
                    if (lock_ack) begin
                        lock_req <= 1'b0;
                        state    <= SPAWN;
                    end
                end
                OVER: ;
                default: state <= SPAWN;
            endcase
        end
    end

endmodule
